// File: rtl/phase_seq_pkg.sv
// Shared types and default sizing for the phase sequencer slice.
package phase_seq_pkg;

    localparam int DEF_W          = 26;
    localparam int DEF_NUM_PHASES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/period_timer.sv
// Up-counter that expires when the count reaches the supplied limit, then wraps to zero.
module period_timer #(
    parameter int W = 26
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    assign o_expire = i_enable && (r_cnt == i_limit);

    // The count never exceeds the limit because expiry wraps it back to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_expire ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Steps through NUM_PHASES programmable-length phases; optional looping is enabled
// by defining PHASE_SEQ_LOOP_EN, which adds the loop input.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int W          = DEF_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
`ifdef PHASE_SEQ_LOOP_EN
    input  logic                          loop,
`endif
    input  logic                          wr_en,
    input  logic [$clog2(NUM_PHASES)-1:0] wr_addr,
    input  logic [W-1:0]                  wr_data,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic                          busy,
    output logic                          phase_tick,
    output logic                          done,
    output logic [1:0]                    dbg_state
);

    localparam int PW = $clog2(NUM_PHASES);

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_table [NUM_PHASES];
    logic [W-1:0]  r_cur_period;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;
    logic          w_tick;
    logic          w_last;
    logic          w_go;
    logic          w_loop;
    logic          w_timer_clear;
    logic          w_timer_en;

`ifdef PHASE_SEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_go          = start && !stop;
    assign w_last        = (r_phase == PW'(NUM_PHASES - 1));
    // Power-of-two phase count: the increment wraps the last phase back to 0.
    assign w_phase_next  = r_phase + 1'b1;
    assign w_timer_en    = (r_state == ST_RUN);
    assign w_timer_clear = (r_state != ST_RUN) || stop;

    period_timer #(.W(W)) u_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .i_limit  (r_cur_period),
        .o_expire (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go) w_state_next = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick && w_last && !w_loop) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state == ST_RUN);
        done       = (r_state == ST_DONE);
        phase_tick = w_tick;
        phase      = r_phase;
        dbg_state  = r_state;
    end

    // Table reads below see the pre-write contents, so a same-edge write is not latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= '0;
            r_cur_period <= '0;
            for (int i = 0; i < NUM_PHASES; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_table[wr_addr] <= wr_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_phase      <= '0;
                        r_cur_period <= r_table[0];
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_phase <= '0;
                    end else if (w_tick) begin
                        r_phase      <= w_phase_next;
                        r_cur_period <= r_table[w_phase_next];
                    end
                end
                default: r_phase <= '0;
            endcase
        end
    end

endmodule
